// File: rtl/bullet_engine.sv
// Enemy bullet stream for the battle phase: spawns one falling bullet at a time at an
// LFSR-chosen column, advances it on the synchronised slow tick and checks it against the player.
module bullet_engine #(
  parameter logic [7:0]  X_MIN     = 8'd16,
  parameter logic [7:0]  X_MAX     = 8'd200,
  parameter logic [7:0]  Y_TOP     = 8'd0,
  parameter logic [7:0]  Y_BOTTOM  = 8'd160,
  parameter logic [7:0]  SPEED     = 8'd4,
  parameter logic [7:0]  HIT_R     = 8'd6,
  parameter logic [3:0]  SPAWN_GAP = 4'd3,
  parameter logic [7:0]  WAVE_LEN  = 8'd8,
  parameter logic [7:0]  DAMAGE    = 8'd5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        start,
  input  logic        enable,
  input  logic [15:0] playerPos,
  output logic [15:0] bulletPos,
  output logic [2:0]  bulletColor,
  output logic        hit,
  output logic [7:0]  damage,
  output logic        busy,
  output logic        wave_done,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_lfsr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_FLY  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        sync1_q, sync2_q, sync3_q, tick_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  bx_q, bx_d, by_q, by_d;
  logic [2:0]  color_q, color_d;
  logic [15:0] pcap_q, pcap_d;
  logic        hit_q, hit_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        tick_d;
  logic        lfsr_fb;
  logic        moved;
  logic [7:0]  px, py, dx, dy;
  logic        collide, rule_ok, hit_now;
  logic [8:0]  y_sum;
  logic        miss;
  logic [7:0]  spawn_x;
  logic [2:0]  spawn_col;
  logic [7:0]  count_inc;

  // Edge detect on the second synchroniser stage; tick_q is the registered one-cycle pulse.
  assign tick_d  = sync2_q & ~sync3_q;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  assign px    = playerPos[15:8];
  assign py    = playerPos[7:0];
  assign dx    = (bx_q >= px) ? (bx_q - px) : (px - bx_q);
  assign dy    = (by_q >= py) ? (by_q - py) : (py - by_q);
  assign moved = (playerPos != pcap_q);

  assign collide   = (dx <= HIT_R) && (dy <= HIT_R);
  assign y_sum     = {1'b0, by_q} + {1'b0, SPEED};
  assign miss      = (y_sum > {1'b0, Y_BOTTOM});
  assign spawn_x   = ((lfsr_q[7:0] >= X_MIN) && (lfsr_q[7:0] <= X_MAX)) ? lfsr_q[7:0] : X_MIN;
  assign spawn_col = lfsr_q[9] ? (lfsr_q[8] ? 3'd3 : 3'd2) : 3'd1;
  assign count_inc = count_q + 8'd1;

  always_comb begin
    rule_ok = 1'b0;
    case (color_q)
      3'd1:    rule_ok = 1'b1;
      3'd2:    rule_ok = moved;
      3'd3:    rule_ok = ~moved;
      default: rule_ok = 1'b0;
    endcase
  end

  assign hit_now = (state_q == S_FLY) && (color_q != 3'd0) && collide && rule_ok;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    count_d = count_q;
    bx_d    = bx_q;
    by_d    = by_q;
    color_d = color_q;
    hit_d   = 1'b0;
    lfsr_d  = tick_q ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
    pcap_d  = tick_q ? playerPos : pcap_q;

    if (!enable) begin
      state_d = S_IDLE;
      color_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            gap_d   = SPAWN_GAP;
            count_d = 8'd0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (tick_q) begin
            if (gap_q == 4'd0) begin
              bx_d    = spawn_x;
              by_d    = Y_TOP;
              color_d = spawn_col;
              state_d = S_FLY;
            end else begin
              gap_d = gap_q - 4'd1;
            end
          end
        end
        S_FLY: begin
          // A hit resolves the bullet even on a tick cycle, so the move is dropped.
          if (hit_now || (tick_q && miss)) begin
            hit_d   = hit_now;
            color_d = 3'd0;
            count_d = count_inc;
            if (count_inc == WAVE_LEN) begin
              state_d = S_DONE;
            end else begin
              gap_d   = SPAWN_GAP;
              state_d = S_GAP;
            end
          end else if (tick_q) begin
            by_d = y_sum[7:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      state_q <= S_IDLE;
      gap_q   <= 4'd0;
      count_q <= 8'd0;
      bx_q    <= 8'd0;
      by_q    <= 8'd0;
      color_q <= 3'd0;
      pcap_q  <= 16'd0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= move_tick;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= tick_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      color_q <= color_d;
      pcap_q  <= pcap_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bulletPos   = {bx_q, by_q};
  assign bulletColor = color_q;
  assign hit         = hit_q;
  assign damage      = hit_q ? DAMAGE : 8'd0;
  assign busy        = busy_q;
  assign wave_done   = done_q;
  assign dbg_state   = state_q;
  assign dbg_lfsr    = lfsr_q;

endmodule
